// File: rtl/spi_master.sv
// spi_master -- single-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Shifts one byte (flag=0) or two bytes (flag=1) out on MOSI under a single
// CS-low window while capturing MISO, and strobes byte_recv once per received
// byte. SCLK half-period is CLK_DIV system clocks.
//
// Ports:
//   i_clock, i_reset          system clock, async active-low reset
//   enable                    0 forces idle / aborts a transfer
//   start_transfer            start request, honoured only in IDLE
//   multi_byte_spi_trans_flag 1 = 16-bit transfer, 0 = 8-bit transfer
//   Tx_Upper_Byte/Lower_Byte  transmit data, latched at start
//   busy, byte_recv           status / per-byte receive strobe
//   Rx_Recv_Byte              most recently received byte
//   CS, SCLK, MOSI, MISO      SPI pins
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       enable,
  input  logic       start_transfer,
  input  logic       multi_byte_spi_trans_flag,
  output logic       busy,
  output logic       byte_recv,
  output logic       MOSI,
  input  logic       MISO,
  output logic       CS,
  output logic       SCLK,
  input  logic [7:0] Tx_Upper_Byte,
  input  logic [7:0] Tx_Lower_Byte,
  output logic [7:0] Rx_Recv_Byte
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;   // index of the bit currently on the wire
  logic        multi;     // latched transfer length
  logic [15:0] tx_shift;  // [15] is the bit currently driven on MOSI
  logic [7:0]  rx_shift;

  logic       phase_end;
  logic       last_bit;
  logic       byte_end;
  logic [7:0] rx_next;

  assign phase_end = (div_cnt == 8'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == (multi ? 4'd15 : 4'd7));
  assign byte_end  = (bit_cnt[2:0] == 3'd7);
  assign rx_next   = {rx_shift[6:0], MISO};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      multi        <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      busy         <= 1'b0;
      byte_recv    <= 1'b0;
      MOSI         <= 1'b0;
      CS           <= 1'b1;
      SCLK         <= 1'b0;
      Rx_Recv_Byte <= '0;
    end else if (!enable) begin
      // Abort: drop straight to idle; Rx_Recv_Byte keeps its last value.
      state     <= IDLE;
      div_cnt   <= '0;
      busy      <= 1'b0;
      byte_recv <= 1'b0;
      MOSI      <= 1'b0;
      CS        <= 1'b1;
      SCLK      <= 1'b0;
    end else begin
      byte_recv <= 1'b0;
      div_cnt   <= phase_end ? 8'd0 : div_cnt + 8'd1;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          CS      <= 1'b1;
          SCLK    <= 1'b0;
          MOSI    <= 1'b0;
          busy    <= 1'b0;
          if (start_transfer) begin
            // 8-bit mode left-justifies Lower so [15] is always the next bit.
            tx_shift <= multi_byte_spi_trans_flag ? {Tx_Upper_Byte, Tx_Lower_Byte}
                                                  : {Tx_Lower_Byte, 8'h00};
            MOSI     <= multi_byte_spi_trans_flag ? Tx_Upper_Byte[7] : Tx_Lower_Byte[7];
            multi    <= multi_byte_spi_trans_flag;
            bit_cnt  <= '0;
            CS       <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            SCLK  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            SCLK     <= 1'b0;
            rx_shift <= rx_next;
            if (byte_end) Rx_Recv_Byte <= rx_next;
            tx_shift <= {tx_shift[14:0], 1'b0};
            // The last bit stays on MOSI through HOLD.
            if (!last_bit) MOSI <= tx_shift[14];
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            // Strobe lands one SCLK half-period after the byte's last sample.
            if (byte_end) byte_recv <= 1'b1;
            if (last_bit) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              SCLK    <= 1'b1;
              state   <= HIGH;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            CS    <= 1'b1;
            MOSI  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed self-checking bench for spi_master (CLK_DIV=4).
// Inputs change and outputs are sampled on the falling edge of i_clock.
module tb_spi_master;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       enable = 1'b1;
  logic       start_transfer = 1'b0;
  logic       multi_byte_spi_trans_flag = 1'b0;
  logic       busy, byte_recv, MOSI, CS, SCLK;
  logic       MISO = 1'b0;
  logic [7:0] Tx_Upper_Byte = '0;
  logic [7:0] Tx_Lower_Byte = '0;
  logic [7:0] Rx_Recv_Byte;

  spi_master #(.CLK_DIV(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .enable(enable),
    .start_transfer(start_transfer),
    .multi_byte_spi_trans_flag(multi_byte_spi_trans_flag),
    .busy(busy), .byte_recv(byte_recv), .MOSI(MOSI), .MISO(MISO),
    .CS(CS), .SCLK(SCLK), .Tx_Upper_Byte(Tx_Upper_Byte),
    .Tx_Lower_Byte(Tx_Lower_Byte), .Rx_Recv_Byte(Rx_Recv_Byte)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the last transfer
  int          busy_cnt, rises, cs_falls, ns;
  int          strobe_cyc [2];
  logic [7:0]  strobe_val [2];
  logic [15:0] mosi_word;

  // Runs one transfer and records what the pins did.
  //   loop      : MISO follows MOSI, else MISO plays slave_word MSB first
  //   abort_fall: drop enable after this many SCLK pulses (0 = never)
  //   restart   : pulse start_transfer again mid-transfer
  //   chg_tx    : change Tx inputs after the start edge
  task automatic xfer(input logic [7:0] up, input logic [7:0] lo, input logic flag,
                      input logic loop, input logic [15:0] slave_word,
                      input int abort_fall, input logic restart, input logic chg_tx);
    int   cyc, falls;
    logic prev_sclk, prev_cs;
    busy_cnt = 0; rises = 0; cs_falls = 0; ns = 0; mosi_word = '0;
    strobe_cyc[0] = -1; strobe_cyc[1] = -1; strobe_val[0] = '0; strobe_val[1] = '0;
    falls = 0; prev_sclk = SCLK; prev_cs = CS;
    @(negedge i_clock);
    Tx_Upper_Byte = up; Tx_Lower_Byte = lo; multi_byte_spi_trans_flag = flag;
    MISO = loop ? (flag ? up[7] : lo[7]) : slave_word[15];
    start_transfer = 1'b1;
    @(negedge i_clock);
    start_transfer = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      if (busy) busy_cnt++;
      if (prev_cs && !CS) cs_falls++;
      if (SCLK && !prev_sclk) begin
        rises++;
        mosi_word = {mosi_word[14:0], MOSI};
      end
      if (!SCLK && prev_sclk) falls++;
      if (byte_recv) begin
        if (ns < 2) begin
          strobe_cyc[ns] = cyc;
          strobe_val[ns] = Rx_Recv_Byte;
        end
        ns++;
      end
      if (!busy && cyc > 0) break;
      MISO = loop ? MOSI : (falls < 16 ? slave_word[15 - falls] : 1'b0);
      if (chg_tx && cyc == 2) begin
        Tx_Lower_Byte = 8'hFF; Tx_Upper_Byte = 8'hFF; multi_byte_spi_trans_flag = ~flag;
      end
      if (restart) start_transfer = (cyc == 20);
      if (abort_fall != 0 && falls == abort_fall && !SCLK) enable = 1'b0;
      prev_sclk = SCLK; prev_cs = CS;
      cyc++;
      @(negedge i_clock);
    end
    start_transfer = 1'b0;
    multi_byte_spi_trans_flag = flag;
    chk("xfer_timeout", 32'(cyc >= 400), 32'd0);
    // The sample that ended the loop is the first idle cycle.
    chk("end_cs", 32'(CS), 32'd1);
    chk("end_sclk", 32'(SCLK), 32'd0);
    chk("end_mosi", 32'(MOSI), 32'd0);
    enable = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cs", 32'(CS), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx", 32'(Rx_Recv_Byte), 32'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    // 8-bit loopback, 0xA5
    xfer(8'h00, 8'hA5, 1'b0, 1'b1, 16'h0, 0, 1'b0, 1'b0);
    chk("t8_rises", rises, 8);
    chk("t8_mosi", 32'(mosi_word[7:0]), 32'hA5);
    chk("t8_nstrobe", ns, 1);
    chk("t8_strobe_cyc", strobe_cyc[0], 68);
    chk("t8_rx", 32'(strobe_val[0]), 32'hA5);
    chk("t8_busy", busy_cnt, 72);
    chk("t8_csfall", cs_falls, 1);

    // 16-bit, slave returns 0x81 then 0x7E
    xfer(8'h3C, 8'hF0, 1'b1, 1'b0, 16'h817E, 0, 1'b0, 1'b0);
    chk("t16_rises", rises, 16);
    chk("t16_mosi", 32'(mosi_word), 32'h3CF0);
    chk("t16_nstrobe", ns, 2);
    chk("t16_strobe0_cyc", strobe_cyc[0], 68);
    chk("t16_strobe0_val", 32'(strobe_val[0]), 32'h81);
    chk("t16_strobe1_cyc", strobe_cyc[1], 132);
    chk("t16_strobe1_val", 32'(strobe_val[1]), 32'h7E);
    chk("t16_busy", busy_cnt, 136);
    chk("t16_csfall", cs_falls, 1);
    chk("t16_rx_final", 32'(Rx_Recv_Byte), 32'h7E);

    // Start pulse while busy is ignored
    xfer(8'h00, 8'h96, 1'b0, 1'b0, 16'hC300, 0, 1'b1, 1'b0);
    chk("rs_rises", rises, 8);
    chk("rs_csfall", cs_falls, 1);
    chk("rs_busy", busy_cnt, 72);
    chk("rs_rx", 32'(Rx_Recv_Byte), 32'hC3);
    repeat (5) @(negedge i_clock);
    chk("rs_idle_busy", 32'(busy), 32'd0);
    chk("rs_idle_cs", 32'(CS), 32'd1);

    // Abort after 3 SCLK pulses
    xfer(8'h00, 8'h3F, 1'b0, 1'b0, 16'hFFFF, 3, 1'b0, 1'b0);
    chk("ab_rises", rises, 3);
    chk("ab_busy", busy_cnt, 25);
    chk("ab_nstrobe", ns, 0);
    chk("ab_rx_kept", 32'(Rx_Recv_Byte), 32'hC3);

    // Tx inputs changed after the start edge have no effect
    xfer(8'h00, 8'h55, 1'b0, 1'b1, 16'h0, 0, 1'b0, 1'b1);
    chk("st_mosi", 32'(mosi_word[7:0]), 32'h55);
    chk("st_rises", rises, 8);
    chk("st_rx", 32'(Rx_Recv_Byte), 32'h55);
    chk("st_busy", busy_cnt, 72);

    // Async reset mid-transfer, checked before any clock edge
    @(negedge i_clock);
    Tx_Lower_Byte = 8'hFF; multi_byte_spi_trans_flag = 1'b1; start_transfer = 1'b1;
    @(negedge i_clock);
    start_transfer = 1'b0;
    repeat (30) @(negedge i_clock);
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("ar_cs", 32'(CS), 32'd1);
    chk("ar_sclk", 32'(SCLK), 32'd0);
    chk("ar_mosi", 32'(MOSI), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_strobe", 32'(byte_recv), 32'd0);
    chk("ar_rx", 32'(Rx_Recv_Byte), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-channel SPI master (mode 0, MSB first) that shifts one or two bytes out on MOSI while capturing MISO, one byte at a time. It sits between a register/control layer and an off-chip SPI peripheral. It generates CS and SCLK from the system clock and reports each completed received byte with a one-cycle strobe.

## Interface
- CLK_DIV, 4: SCLK half-period in i_clock cycles; legal range 1..255.
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; 0 forces idle and aborts any transfer.
- start_transfer  in  1  request a transfer; sampled only in IDLE with enable=1.
- multi_byte_spi_trans_flag  in  1  1 = 16-bit transfer (two bytes); 0 = 8-bit transfer.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- byte_recv  out  1  one-cycle strobe; Rx_Recv_Byte is valid in this cycle.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- CS  out  1  chip select, active low.
- SCLK  out  1  serial clock, idle low.
- Tx_Upper_Byte  in  8  first byte of a 16-bit transfer.
- Tx_Lower_Byte  in  8  only byte of an 8-bit transfer; second byte of a 16-bit transfer.
- Rx_Recv_Byte  out  8  most recently received byte.

## Operation
- All outputs are registered.
- Reset values: CS=1, SCLK=0, MOSI=0, busy=0, byte_recv=0, Rx_Recv_Byte=0x00, state IDLE.
- States:
  - IDLE: CS=1, SCLK=0, MOSI=0, busy=0.
  - SETUP: CS=0, SCLK=0, first bit on MOSI.
  - HIGH: SCLK=1.
  - LOW: SCLK=0.
  - HOLD: CS=0, SCLK=0 after the last bit.
- Start: in IDLE with enable=1 and start_transfer=1, latch Tx_Upper_Byte, Tx_Lower_Byte and the flag, then go to SETUP. The 16-bit shift word is {Upper, Lower}; in 8-bit mode it is {Lower}.
- Each phase (SETUP, HIGH, LOW, HOLD) lasts exactly CLK_DIV cycles. Transitions: SETUP→HIGH→LOW→HIGH… for each bit, then the final LOW→HOLD→IDLE.
- At the i_clock edge ending each HIGH phase:
  - MISO is shifted into the receive register, MSB first.
  - MOSI is updated to the next transmit bit; it holds the last bit through HOLD.
- After the 8th bit of each byte is sampled:
  - Rx_Recv_Byte is loaded on that edge.
  - byte_recv is high for exactly one cycle.
- In 16-bit mode the second byte follows with no gap or extra CS toggle. Two byte_recv strobes occur; Rx_Recv_Byte finally holds the second received byte.
- start_transfer while busy=1 is ignored (not queued).
- enable=0 in any state: next cycle IDLE, CS=1, SCLK=0, MOSI=0, busy=0, no byte_recv. Rx_Recv_Byte keeps its last value.
- Input changes on Tx_* or the flag during a transfer have no effect.

## Timing
- Start accepted at edge E0. SETUP begins after E0: CS=0, busy=1, MOSI=first MSB.
- First SCLK rise occurs CLK_DIV cycles after CS falls.
- Each bit is 2·CLK_DIV cycles: HIGH then LOW.
- busy duration is CLK_DIV·(2 + 2·N) cycles, N=8 or 16. With CLK_DIV=4: 72 cycles (8-bit), 136 cycles (16-bit).
- byte_recv for byte k (k=1,2) asserts CLK_DIV·(1+16k) cycles after busy rises. With CLK_DIV=4 the strobes come at cycles 68 and 132.
- A new start is accepted in the first cycle busy=0, giving a minimum of one IDLE cycle with CS=1 between transfers.
- Asynchronous reset mid-transfer: outputs go immediately to their reset values.

## Test plan
- Reset: assert i_reset=0 mid-transfer → CS=1, SCLK=0, MOSI=0, busy=0, byte_recv=0, Rx_Recv_Byte=0x00 without waiting for a clock.
- 8-bit loopback: MISO tied to MOSI, Lower=0xA5, flag=0, start pulse → MOSI bits 1,0,1,0,0,1,0,1 on 8 SCLK rises; one byte_recv with Rx_Recv_Byte=0xA5; busy high 72 cycles.
- 16-bit: Upper=0x3C, Lower=0xF0, flag=1, slave returns 0x81 then 0x7E → 16 SCLK pulses under one CS low; byte_recv strobes at 68 and 132 cycles with 0x81 then 0x7E; busy high 136 cycles.
- Start during busy: second start_transfer pulse mid-transfer → ignored; exactly 8 SCLK pulses and one CS low period.
- Abort: enable driven to 0 after 3 SCLK pulses → next cycle CS=1, busy=0, SCLK=0; no byte_recv; Rx_Recv_Byte unchanged.
- Input stability: change Tx_Lower_Byte from 0x55 to 0xFF after the start edge → MOSI still shifts 0x55.
